// File: rtl/apb2axi_pkg.sv
// apb2axi_pkg: shared tag width and scheduler state encoding
package apb2axi_pkg;
  localparam int TAG_W = 4;
  typedef enum logic [0:0] {S_IDLE = 1'b0, S_OFFER = 1'b1} sched_state_e;
endpackage

// File: rtl/apb2axi_rr_arb.sv
// apb2axi_rr_arb: combinational round-robin pick, first request at or after ptr_i
module apb2axi_rr_arb
  import apb2axi_pkg::*;
#(
  parameter int N = 2**TAG_W
) (
  input  logic [N-1:0]     req_i,
  input  logic [TAG_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_oh_o,
  output logic [TAG_W-1:0] gnt_idx_o,
  output logic             gnt_vld_o
);
  logic [TAG_W-1:0] idx;
  // Scan from farthest to nearest so the last hit is the closest one to ptr_i.
  always_comb begin
    idx = '0;
    gnt_idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = ptr_i + TAG_W'(i);
      gnt_idx_o = req_i[idx] ? idx : gnt_idx_o;
    end
    gnt_vld_o = |req_i;
    gnt_oh_o = gnt_vld_o ? N'(1) << gnt_idx_o : '0;
  end
endmodule

// File: rtl/apb2axi_txn_sched.sv
// apb2axi_txn_sched: picks pending directory tags and offers them to the AR/AW builders,
// tracking in-flight tags and per-channel outstanding counts (channel 0 = read, 1 = write).
module apb2axi_txn_sched
  import apb2axi_pkg::*;
#(
  parameter int NUM_TAGS = 2**TAG_W,
  parameter int MAX_OUTSTANDING = 8,
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                pclk,
  input  logic                preset,
  input  logic                sched_en,
  input  logic [NUM_TAGS-1:0] dir_pend_vld,
  input  logic [NUM_TAGS-1:0] dir_pend_is_write,
  output logic                ar_issue_vld,
  output logic [TAG_W-1:0]    ar_issue_tag,
  input  logic                ar_issue_rdy,
  output logic                aw_issue_vld,
  output logic [TAG_W-1:0]    aw_issue_tag,
  input  logic                aw_issue_rdy,
  input  logic                rd_done_vld,
  input  logic [TAG_W-1:0]    rd_done_tag,
  input  logic                wr_done_vld,
  input  logic [TAG_W-1:0]    wr_done_tag,
  output logic [CNT_W-1:0]    rd_outstanding,
  output logic [CNT_W-1:0]    wr_outstanding,
  output logic                sched_err
);
  sched_state_e        st_q [2], st_d [2];
  logic [TAG_W-1:0]    tag_q [2], tag_d [2], ptr_q [2], ptr_d [2], gnt_idx [2], done_tag [2];
  logic [NUM_TAGS-1:0] oh_q [2], oh_d [2], mask_q [2], mask_d [2], cand [2], gnt_oh [2];
  logic [CNT_W-1:0]    cnt_q [2], cnt_d [2];
  logic                gnt_vld [2], rdy [2], done_vld [2], hs [2], ok [2], go [2];
  logic                err_q, err_d;
  assign rdy[0] = ar_issue_rdy;
  assign rdy[1] = aw_issue_rdy;
  assign done_vld[0] = rd_done_vld;
  assign done_vld[1] = wr_done_vld;
  assign done_tag[0] = rd_done_tag;
  assign done_tag[1] = wr_done_tag;
  always_comb begin
    for (int c = 0; c < 2; c++)
      cand[c] = dir_pend_vld & (c == 1 ? dir_pend_is_write : ~dir_pend_is_write) & ~(mask_q[0] | mask_q[1]);
  end
  for (genvar g = 0; g < 2; g++) begin : g_arb
    apb2axi_rr_arb #(.N(NUM_TAGS)) u_arb (
      .req_i    (cand[g]),
      .ptr_i    (ptr_q[g]),
      .gnt_oh_o (gnt_oh[g]),
      .gnt_idx_o(gnt_idx[g]),
      .gnt_vld_o(gnt_vld[g])
    );
  end
  // Masks are per channel so a done on the wrong channel is flagged, not silently cleared.
  always_comb begin
    err_d = err_q;
    for (int c = 0; c < 2; c++) begin
      hs[c] = st_q[c] == S_OFFER && rdy[c];
      ok[c] = done_vld[c] && mask_q[c][done_tag[c]];
      go[c] = st_q[c] == S_IDLE && sched_en && gnt_vld[c] && cnt_q[c] < CNT_W'(MAX_OUTSTANDING);
      st_d[c] = go[c] ? S_OFFER : hs[c] ? S_IDLE : st_q[c];
      tag_d[c] = go[c] ? gnt_idx[c] : tag_q[c];
      oh_d[c] = go[c] ? gnt_oh[c] : oh_q[c];
      ptr_d[c] = hs[c] ? tag_q[c] + 1'b1 : ptr_q[c];
      mask_d[c] = (mask_q[c] | (hs[c] ? oh_q[c] : '0)) & ~(ok[c] ? NUM_TAGS'(1) << done_tag[c] : '0);
      cnt_d[c] = cnt_q[c] + CNT_W'(hs[c]) - CNT_W'(ok[c]);
      err_d = err_d | (done_vld[c] && !ok[c]);
    end
  end
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      for (int c = 0; c < 2; c++) begin
        st_q[c] <= S_IDLE;
        tag_q[c] <= '0;
        oh_q[c] <= '0;
        ptr_q[c] <= '0;
        mask_q[c] <= '0;
        cnt_q[c] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        st_q[c] <= st_d[c];
        tag_q[c] <= tag_d[c];
        oh_q[c] <= oh_d[c];
        ptr_q[c] <= ptr_d[c];
        mask_q[c] <= mask_d[c];
        cnt_q[c] <= cnt_d[c];
      end
      err_q <= err_d;
    end
  end
  assign ar_issue_vld = st_q[0] == S_OFFER;
  assign aw_issue_vld = st_q[1] == S_OFFER;
  assign ar_issue_tag = tag_q[0];
  assign aw_issue_tag = tag_q[1];
  assign rd_outstanding = cnt_q[0];
  assign wr_outstanding = cnt_q[1];
  assign sched_err = err_q;
endmodule

// File: tb/tb_apb2axi_txn_sched.sv
// tb_apb2axi_txn_sched: directed vectors with hand-computed expectations, MAX_OUTSTANDING=2
module tb_apb2axi_txn_sched;
  logic        pclk = 1'b0, preset = 1'b1, sched_en = 1'b0;
  logic [15:0] dir_pend_vld = '0, dir_pend_is_write = '0;
  logic        ar_issue_vld, aw_issue_vld, ar_issue_rdy = 1'b0, aw_issue_rdy = 1'b0;
  logic [3:0]  ar_issue_tag, aw_issue_tag, rd_done_tag = '0, wr_done_tag = '0;
  logic        rd_done_vld = 1'b0, wr_done_vld = 1'b0, sched_err;
  logic [1:0]  rd_outstanding, wr_outstanding;
  int checks = 0, failures = 0;
  apb2axi_txn_sched #(.NUM_TAGS(16), .MAX_OUTSTANDING(2)) dut (
    .pclk(pclk), .preset(preset), .sched_en(sched_en),
    .dir_pend_vld(dir_pend_vld), .dir_pend_is_write(dir_pend_is_write),
    .ar_issue_vld(ar_issue_vld), .ar_issue_tag(ar_issue_tag), .ar_issue_rdy(ar_issue_rdy),
    .aw_issue_vld(aw_issue_vld), .aw_issue_tag(aw_issue_tag), .aw_issue_rdy(aw_issue_rdy),
    .rd_done_vld(rd_done_vld), .rd_done_tag(rd_done_tag),
    .wr_done_vld(wr_done_vld), .wr_done_tag(wr_done_tag),
    .rd_outstanding(rd_outstanding), .wr_outstanding(wr_outstanding), .sched_err(sched_err)
  );
  always #5 pclk = ~pclk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic nb(input int n);
    repeat (n) @(negedge pclk);
  endtask
  initial begin
    nb(2);
    chk("rst_ar_vld", ar_issue_vld, 0);
    chk("rst_aw_vld", aw_issue_vld, 0);
    chk("rst_rd_cnt", rd_outstanding, 0);
    chk("rst_err", sched_err, 0);
    preset = 1'b0;
    sched_en = 1'b1;
    ar_issue_rdy = 1'b1;
    dir_pend_vld = 16'h0088;
    nb(1);
    chk("a_vld1", ar_issue_vld, 1);
    chk("a_tag3", ar_issue_tag, 3);
    chk("a_cnt0", rd_outstanding, 0);
    nb(1);
    chk("a_idle", ar_issue_vld, 0);
    chk("a_cnt1", rd_outstanding, 1);
    nb(1);
    chk("a_tag7", ar_issue_tag, 7);
    chk("a_vld2", ar_issue_vld, 1);
    nb(1);
    chk("a_cnt2", rd_outstanding, 2);
    nb(1);
    chk("a_noreissue", ar_issue_vld, 0);
    dir_pend_vld = '0;
    rd_done_vld = 1'b1;
    rd_done_tag = 3;
    nb(1);
    chk("a_done3", rd_outstanding, 1);
    rd_done_tag = 7;
    nb(1);
    rd_done_vld = 1'b0;
    chk("a_done7", rd_outstanding, 0);
    chk("a_err", sched_err, 0);
    ar_issue_rdy = 1'b0;
    dir_pend_vld = 16'h0020;
    nb(1);
    dir_pend_vld = '0;
    sched_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("b_vld", ar_issue_vld, 1);
      chk("b_tag5", ar_issue_tag, 5);
      if (i < 3) nb(1);
    end
    ar_issue_rdy = 1'b1;
    nb(1);
    chk("b_issued", ar_issue_vld, 0);
    chk("b_cnt1", rd_outstanding, 1);
    rd_done_vld = 1'b1;
    rd_done_tag = 5;
    nb(1);
    rd_done_vld = 1'b0;
    sched_en = 1'b1;
    dir_pend_vld = 16'h0017;
    nb(1);
    chk("c_tag0", ar_issue_tag, 0);
    nb(2);
    chk("c_tag1", ar_issue_tag, 1);
    nb(2);
    chk("c_full_vld", ar_issue_vld, 0);
    chk("c_full_cnt", rd_outstanding, 2);
    nb(1);
    chk("c_hold", ar_issue_vld, 0);
    rd_done_vld = 1'b1;
    rd_done_tag = 0;
    nb(1);
    rd_done_vld = 1'b0;
    chk("c_not_yet", ar_issue_vld, 0);
    chk("c_cnt_dec", rd_outstanding, 1);
    nb(1);
    chk("c_third_vld", ar_issue_vld, 1);
    chk("c_third_tag", ar_issue_tag, 2);
    nb(1);
    chk("c_cnt_max", rd_outstanding, 2);
    dir_pend_vld = '0;
    rd_done_vld = 1'b1;
    rd_done_tag = 1;
    nb(1);
    rd_done_tag = 2;
    nb(1);
    rd_done_vld = 1'b0;
    dir_pend_vld = 16'h4000;
    nb(1);
    chk("d_tag14", ar_issue_tag, 14);
    nb(1);
    dir_pend_vld = 16'h8001;
    rd_done_vld = 1'b1;
    rd_done_tag = 14;
    nb(1);
    rd_done_vld = 1'b0;
    chk("d_tag15", ar_issue_tag, 15);
    chk("d_vld15", ar_issue_vld, 1);
    nb(2);
    chk("d_wrap0", ar_issue_tag, 0);
    chk("d_vld0", ar_issue_vld, 1);
    nb(1);
    chk("d_cnt2", rd_outstanding, 2);
    dir_pend_vld = '0;
    rd_done_vld = 1'b1;
    rd_done_tag = 15;
    nb(1);
    rd_done_tag = 0;
    nb(1);
    rd_done_vld = 1'b0;
    wr_done_vld = 1'b1;
    wr_done_tag = 9;
    nb(1);
    wr_done_vld = 1'b0;
    chk("e_err", sched_err, 1);
    chk("e_wr_cnt", wr_outstanding, 0);
    chk("e_rd_cnt", rd_outstanding, 0);
    aw_issue_rdy = 1'b1;
    dir_pend_vld = 16'h0200;
    dir_pend_is_write = 16'h0200;
    nb(1);
    chk("e_aw_tag9", aw_issue_tag, 9);
    chk("e_aw_vld", aw_issue_vld, 1);
    chk("e_ar_quiet", ar_issue_vld, 0);
    nb(1);
    chk("e_wr_cnt1", wr_outstanding, 1);
    dir_pend_vld = 16'h0800;
    dir_pend_is_write = 16'h0800;
    nb(1);
    chk("e_aw_tag11", aw_issue_tag, 11);
    wr_done_vld = 1'b1;
    wr_done_tag = 9;
    nb(1);
    wr_done_vld = 1'b0;
    chk("e_same_cyc_cnt", wr_outstanding, 1);
    chk("e_aw_idle", aw_issue_vld, 0);
    dir_pend_vld = 16'h0040;
    dir_pend_is_write = '0;
    ar_issue_rdy = 1'b0;
    nb(1);
    chk("f_offer", ar_issue_vld, 1);
    chk("f_tag6", ar_issue_tag, 6);
    #2 preset = 1'b1;
    #1;
    chk("f_async_vld", ar_issue_vld, 0);
    chk("f_async_tag", ar_issue_tag, 0);
    chk("f_wr_cnt", wr_outstanding, 0);
    chk("f_err", sched_err, 0);
    nb(1);
    preset = 1'b0;
    dir_pend_vld = '0;
    nb(1);
    chk("f_rd_cnt", rd_outstanding, 0);
    chk("f_wr_cnt2", wr_outstanding, 0);
    chk("f_ar_idle", ar_issue_vld, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
